// File: rtl/rx_byte_fifo.sv
// rx_byte_fifo: byte buffer between the UART receiver and its consumer.
// The receiver pushes with a one-cycle strobe and cannot be stalled. The consumer reads a
// first-word-fall-through valid/ready stream. Bytes that arrive while full are dropped and
// latched in a sticky overflow flag.
// Optional build macro RXFIFO_EOP_TAG_EN: each entry carries an end-of-packet tag, set by
// rx_endofpacket on the most recently written byte and presented on out_last.
module rx_byte_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [7:0]    rx_data,
   input  logic          rx_data_ready,
   input  logic          rx_endofpacket,
   output logic [7:0]    out_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          out_last,
   output logic [AW:0]   fifo_count,
   output logic          full,
   output logic          overflow,
   input  logic          clear_overflow
);

   localparam logic [AW:0]   FullCount = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CountOne  = (AW+1)'(1);
   localparam logic [AW-1:0] PtrOne    = AW'(1);

   // Byte storage; deliberately not reset.
   logic [7:0]    mem [DEPTH];

   logic [AW-1:0] wrPtrQ, wrPtrD;
   logic [AW-1:0] rdPtrQ, rdPtrD;
   logic [AW:0]   countQ, countD;
   logic          overflowQ, overflowD;

   logic          isEmpty;
   logic          isFull;
   logic          doPush;
   logic          doPop;
   logic          dropByte;

   // Handshake decode; fullness is judged on the pre-pop occupancy.
   always_comb begin
      isEmpty  = (countQ == '0);
      isFull   = (countQ == FullCount);
      doPush   = rx_data_ready & ~isFull;
      dropByte = rx_data_ready & isFull;
      doPop    = ~isEmpty & out_ready;
   end

   // Next-state for pointers, occupancy and the sticky overflow flag.
   always_comb begin
      wrPtrD    = wrPtrQ;
      rdPtrD    = rdPtrQ;
      countD    = countQ;
      overflowD = overflowQ;

      if (doPush) begin
         wrPtrD = wrPtrQ + PtrOne;
      end
      if (doPop) begin
         rdPtrD = rdPtrQ + PtrOne;
      end

      case ({doPush, doPop})
         2'b10:   countD = countQ + CountOne;
         2'b01:   countD = countQ - CountOne;
         default: countD = countQ;
      endcase

      // Set dominates clear so a drop is never hidden by a coincident clear.
      if (dropByte) begin
         overflowD = 1'b1;
      end else if (clear_overflow) begin
         overflowD = 1'b0;
      end
   end

   // Control state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrPtrQ    <= '0;
         rdPtrQ    <= '0;
         countQ    <= '0;
         overflowQ <= 1'b0;
      end else begin
         wrPtrQ    <= wrPtrD;
         rdPtrQ    <= rdPtrD;
         countQ    <= countD;
         overflowQ <= overflowD;
      end
   end

   // Byte array write port.
   always_ff @(posedge clk) begin
      if (doPush) begin
         mem[wrPtrQ] <= rx_data;
      end
   end

   // Stream outputs; data is forced to zero while empty.
   always_comb begin
      out_valid  = ~isEmpty;
      out_data   = isEmpty ? 8'h00 : mem[rdPtrQ];
      fifo_count = countQ;
      full       = isFull;
      overflow   = overflowQ;
   end

`ifdef RXFIFO_EOP_TAG_EN
   logic [DEPTH-1:0] tagQ, tagD;
   logic [AW-1:0]    lastPtr;
   logic             tagKeep;

   // Tag the last written entry only if it is still buffered after this cycle.
   // A push in the same cycle writes a different slot (DEPTH >= 2), so both updates coexist.
   always_comb begin
      lastPtr = wrPtrQ - PtrOne;
      tagKeep = rx_endofpacket & ~isEmpty & ~((countQ == CountOne) & doPop);
      tagD    = tagQ;
      if (doPush) begin
         tagD[wrPtrQ] = 1'b0;
      end
      if (tagKeep) begin
         tagD[lastPtr] = 1'b1;
      end
   end

   // Tag storage register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tagQ <= '0;
      end else begin
         tagQ <= tagD;
      end
   end

   // Head tag, qualified by valid.
   always_comb begin
      out_last = tagQ[rdPtrQ] & ~isEmpty;
   end
`else
   logic unusedEop;

   // Packet tagging is not built; the end-of-packet input is intentionally sunk.
   always_comb begin
      unusedEop = rx_endofpacket;
      out_last  = 1'b0;
   end
`endif

endmodule
